// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: FSM state encoding,
// instruction classes, opcode/funct codes, ALU op codes and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6
  } state_t;

  // Instruction class produced by the decoder; selects the path after DECODE.
  localparam logic [2:0] C_ALU     = 3'd0;
  localparam logic [2:0] C_LOAD    = 3'd1;
  localparam logic [2:0] C_STORE   = 3'd2;
  localparam logic [2:0] C_BRANCH  = 3'd3;
  localparam logic [2:0] C_JUMP    = 3'd4;
  localparam logic [2:0] C_ILLEGAL = 3'd7;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // ALU op codes; zero-extended to the alu_ctrl port width.
  localparam logic [3:0] ALUOP_NOP  = 4'd0;
  localparam logic [3:0] ALUOP_ADD  = 4'd1;
  localparam logic [3:0] ALUOP_SUB  = 4'd2;
  localparam logic [3:0] ALUOP_AND  = 4'd3;
  localparam logic [3:0] ALUOP_OR   = 4'd4;
  localparam logic [3:0] ALUOP_XOR  = 4'd5;
  localparam logic [3:0] ALUOP_NOR  = 4'd6;
  localparam logic [3:0] ALUOP_SLT  = 4'd7;
  localparam logic [3:0] ALUOP_SLTU = 4'd8;
  localparam logic [3:0] ALUOP_SLL  = 4'd9;
  localparam logic [3:0] ALUOP_SRL  = 4'd10;
  localparam logic [3:0] ALUOP_SRA  = 4'd11;
  localparam logic [3:0] ALUOP_LUI  = 4'd12;
  localparam logic [3:0] ALUOP_ADDU = 4'd13;
  localparam logic [3:0] ALUOP_SUBU = 4'd14;

  // Immediate extension modes
  localparam logic [1:0] EXT_ZERO    = 2'd0;
  localparam logic [1:0] EXT_SIGNED  = 2'd1;
  localparam logic [1:0] EXT_HIGHPOS = 2'd2;

  // Datapath mux selects
  localparam logic [1:0] PC_SEQ     = 2'b00;
  localparam logic [1:0] PC_BRANCH  = 2'b01;
  localparam logic [1:0] PC_JUMP    = 2'b10;
  localparam logic [1:0] PC_JR      = 2'b11;
  localparam logic [1:0] RD_RT      = 2'b00;
  localparam logic [1:0] RD_RD      = 2'b01;
  localparam logic [1:0] RD_RA      = 2'b10;
  localparam logic [1:0] WB_ALU     = 2'b00;
  localparam logic [1:0] WB_MEM     = 2'b01;
  localparam logic [1:0] WB_PC      = 2'b10;
  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_SHAMT = 2'b10;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decoder: opcode/funct -> class plus the
// EXEC-phase datapath controls. Anything not listed decodes as illegal.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 5
) (
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  output logic [2:0]         cls,
  output logic [ALUOP_W-1:0] alu_ctrl,
  output logic [1:0]         ext_op,
  output logic [1:0]         reg_dst,
  output logic [1:0]         alu_src_b,
  output logic               legal
);

  logic [3:0] aluop;

  // Classify the instruction and pick ALU op, extension and operand selects
  always_comb begin
    cls       = C_ILLEGAL;
    aluop     = ALUOP_NOP;
    ext_op    = EXT_ZERO;
    reg_dst   = RD_RT;
    alu_src_b = SRCB_RT;
    case (opcode)
      OP_RTYPE: begin
        cls     = C_ALU;
        reg_dst = RD_RD;
        case (funct)
          FN_ADD:  aluop = ALUOP_ADD;
          FN_ADDU: aluop = ALUOP_ADDU;
          FN_SUB:  aluop = ALUOP_SUB;
          FN_SUBU: aluop = ALUOP_SUBU;
          FN_AND:  aluop = ALUOP_AND;
          FN_OR:   aluop = ALUOP_OR;
          FN_XOR:  aluop = ALUOP_XOR;
          FN_NOR:  aluop = ALUOP_NOR;
          FN_SLT:  aluop = ALUOP_SLT;
          FN_SLTU: aluop = ALUOP_SLTU;
          FN_SLL:  begin aluop = ALUOP_SLL; alu_src_b = SRCB_SHAMT; end
          FN_SRL:  begin aluop = ALUOP_SRL; alu_src_b = SRCB_SHAMT; end
          FN_SRA:  begin aluop = ALUOP_SRA; alu_src_b = SRCB_SHAMT; end
          FN_JR:   cls = C_JUMP;
          default: cls = C_ILLEGAL;
        endcase
      end
      OP_ADDI: begin cls = C_ALU; aluop = ALUOP_ADD; ext_op = EXT_SIGNED;  alu_src_b = SRCB_IMM; end
      OP_SLTI: begin cls = C_ALU; aluop = ALUOP_SLT; ext_op = EXT_SIGNED;  alu_src_b = SRCB_IMM; end
      OP_ORI:  begin cls = C_ALU; aluop = ALUOP_OR;  ext_op = EXT_ZERO;    alu_src_b = SRCB_IMM; end
      OP_LUI:  begin cls = C_ALU; aluop = ALUOP_LUI; ext_op = EXT_HIGHPOS; alu_src_b = SRCB_IMM; end
      OP_LW:   begin cls = C_LOAD;  aluop = ALUOP_ADD; ext_op = EXT_SIGNED; alu_src_b = SRCB_IMM; end
      OP_SW:   begin cls = C_STORE; aluop = ALUOP_ADD; ext_op = EXT_SIGNED; alu_src_b = SRCB_IMM; end
      OP_BEQ, OP_BNE: begin cls = C_BRANCH; aluop = ALUOP_SUB; end
      OP_J, OP_JAL:   cls = C_JUMP;
      default:        cls = C_ILLEGAL;
    endcase
  end

  assign alu_ctrl = ALUOP_W'(aluop);
  assign legal    = (cls != C_ILLEGAL);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM. Sequences FETCH/DECODE/EXEC/MEM/WB (plus
// BRANCH and JUMP) over one shared memory port.
// Memory handshake: mem_req is held high for the whole FETCH or MEM state;
// an access completes in the cycle where mem_req=1 and mem_ready=1, and
// mem_ready is ignored whenever mem_req=0. A wait longer than MEM_TIMEOUT
// cycles aborts the access with a bus_err pulse and returns to FETCH.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               pc_wr,
  output logic [1:0]         pc_src,
  output logic               ir_wr,
  output logic               reg_wr,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wb_sel,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         ext_op,
  output logic [ALUOP_W-1:0] alu_ctrl,
  output logic               illegal,
  output logic               bus_err
);

  state_t             state;
  state_t             state_nx;
  logic [TO_W-1:0]    wait_cnt;
  logic [2:0]         dec_cls;
  logic [ALUOP_W-1:0] dec_alu;
  logic [1:0]         dec_ext;
  logic [1:0]         dec_reg_dst;
  logic [1:0]         dec_srcb;
  logic               dec_legal;
  logic               mem_phase;
  logic               timeout;

  mc_ctrl_decode #(.ALUOP_W(ALUOP_W)) u_decode (
    .opcode    (opcode),
    .funct     (funct),
    .cls       (dec_cls),
    .alu_ctrl  (dec_alu),
    .ext_op    (dec_ext),
    .reg_dst   (dec_reg_dst),
    .alu_src_b (dec_srcb),
    .legal     (dec_legal)
  );

  assign mem_phase = (state == S_FETCH) || (state == S_MEM);
  // mem_ready in the final allowed cycle still completes the access.
  assign timeout   = mem_phase && !mem_ready && (MEM_TIMEOUT != 0) &&
                     (wait_cnt == TO_W'(MEM_TIMEOUT));

  // State register and memory-wait counter; the counter restarts on every
  // state change or abort. With MEM_TIMEOUT=0 it free-runs and is never compared.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      if (!mem_phase || timeout || (state_nx != state)) wait_cnt <= '0;
      else                                              wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Next-state selection
  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  if (mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        case (dec_cls)
          C_ALU, C_LOAD, C_STORE: state_nx = S_EXEC;
          C_BRANCH:               state_nx = S_BRANCH;
          C_JUMP:                 state_nx = S_JUMP;
          default:                state_nx = S_FETCH;
        endcase
      end
      S_EXEC:   state_nx = ((dec_cls == C_LOAD) || (dec_cls == C_STORE)) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_ready)    state_nx = (dec_cls == C_STORE) ? S_FETCH : S_WB;
        else if (timeout) state_nx = S_FETCH;
      end
      S_WB, S_BRANCH, S_JUMP: state_nx = S_FETCH;
      default:                state_nx = S_FETCH;
    endcase
  end

  // Per-state datapath strobes and selects; everything is quiet during rst
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    pc_wr     = 1'b0;
    pc_src    = PC_SEQ;
    ir_wr     = 1'b0;
    reg_wr    = 1'b0;
    reg_dst   = RD_RT;
    wb_sel    = WB_ALU;
    alu_src_b = SRCB_RT;
    ext_op    = EXT_ZERO;
    alu_ctrl  = '0;
    illegal   = 1'b0;
    bus_err   = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_wr   = mem_ready;
          pc_wr   = mem_ready;
          bus_err = timeout;
        end
        S_DECODE: illegal = !dec_legal;
        S_EXEC: begin
          alu_ctrl  = dec_alu;
          ext_op    = dec_ext;
          alu_src_b = dec_srcb;
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = (dec_cls == C_STORE) && !timeout;
          bus_err = timeout;
        end
        S_WB: begin
          reg_wr  = 1'b1;
          reg_dst = dec_reg_dst;
          wb_sel  = (dec_cls == C_LOAD) ? WB_MEM : WB_ALU;
        end
        S_BRANCH: begin
          alu_ctrl = ALUOP_W'(ALUOP_SUB);
          if (((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero)) begin
            pc_wr  = 1'b1;
            pc_src = PC_BRANCH;
          end
        end
        S_JUMP: begin
          pc_wr = 1'b1;
          if (opcode == OP_RTYPE) begin
            pc_src = PC_JR;
          end else begin
            pc_src = PC_JUMP;
            if (opcode == OP_JAL) begin
              reg_wr  = 1'b1;
              reg_dst = RD_RA;
              wb_sel  = WB_PC;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
